// File: rtl/operand_injector.sv
// operand_injector: queues operand pairs from a local producer and
// serialises each one as an A/B beat pair on an AXI-Stream master.
module operand_injector #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2,
    parameter int DEPTH  = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       OP_VALID,
    output logic                       OP_READY,
    input  logic [TDATAW-1:0]          OP_A,
    input  logic [TDATAW-1:0]          OP_B,
    input  logic [TDESTW-1:0]          OP_DEST,
    output logic                       AXIS_M_TVALID,
    input  logic                       AXIS_M_TREADY,
    output logic [TDATAW-1:0]          AXIS_M_TDATA,
    output logic                       AXIS_M_TLAST,
    output logic [TIDW-1:0]            AXIS_M_TID,
    output logic [TDESTW-1:0]          AXIS_M_TDEST,
    output logic [$clog2(DEPTH):0]     FIFO_LEVEL,
    output logic [15:0]                PAIRS_SENT
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND_A = 2'd1,
        SEND_B = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [TDATAW-1:0] mem_a [DEPTH];
    logic [TDATAW-1:0] mem_b [DEPTH];
    logic [TDESTW-1:0] mem_d [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level_q;
    logic [TIDW-1:0] tid_q;
    logic [15:0]     sent_q;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic more_after_pop;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // Ready comes only from the registered level and is held low in reset.
    assign OP_READY = RST_N & ~full;

    assign push = OP_VALID & OP_READY;
    assign pop  = (state_q == SEND_B) & AXIS_M_TREADY;

    // Another pair remains after this pop if one is queued behind the head
    // or one is arriving in the same cycle.
    assign more_after_pop = (level_q > LW'(1)) |
                            ((level_q == LW'(1)) & push);

    assign FIFO_LEVEL = level_q;
    assign PAIRS_SENT = sent_q;

    // Pair storage; contents are don't-care until written by a push.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_a[wr_ptr] <= OP_A;
            mem_b[wr_ptr] <= OP_B;
            mem_d[wr_ptr] <= OP_DEST;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case (1'b1)
                push & ~pop: level_q <= level_q + LW'(1);
                pop & ~push: level_q <= level_q - LW'(1);
                default:     level_q <= level_q;
            endcase
        end
    end

    // Transaction ID and saturating completed-pair counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tid_q  <= '0;
            sent_q <= '0;
        end else if (pop) begin
            tid_q <= tid_q + TIDW'(1);
            if (sent_q != 16'hFFFF) sent_q <= sent_q + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state and AXIS outputs decoded from state and FIFO head.
    always_comb begin
        state_d       = state_q;
        AXIS_M_TVALID = 1'b0;
        AXIS_M_TDATA  = '0;
        AXIS_M_TLAST  = 1'b0;
        AXIS_M_TID    = '0;
        AXIS_M_TDEST  = '0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = SEND_A;
            end
            SEND_A: begin
                AXIS_M_TVALID = 1'b1;
                AXIS_M_TDATA  = mem_a[rd_ptr];
                AXIS_M_TID    = tid_q;
                AXIS_M_TDEST  = mem_d[rd_ptr];
                if (AXIS_M_TREADY) state_d = SEND_B;
            end
            SEND_B: begin
                AXIS_M_TVALID = 1'b1;
                AXIS_M_TDATA  = mem_b[rd_ptr];
                AXIS_M_TLAST  = 1'b1;
                AXIS_M_TID    = tid_q;
                AXIS_M_TDEST  = mem_d[rd_ptr];
                if (AXIS_M_TREADY) begin
                    state_d = more_after_pop ? SEND_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/operand_injector.md
Name: operand_injector

Overview:
Upstream feeder for the two-operand adder stage on the NoC.
- Accepts operand pairs from a local producer over a valid/ready interface and queues them in a small FIFO.
- Serialises each pair onto an AXI-Stream master as two beats: operand A with TLAST=0, then operand B with TLAST=1, tagged with the destination and a rolling transaction ID.
- Keeps a count of pairs sent, for software visibility and test.

Parameters:
- TDATAW, 32, operand/beat data width
- TDESTW, 4, AXIS TDEST width
- TIDW, 2, AXIS TID width; TID wraps modulo 2^TIDW
- DEPTH, 4, pair FIFO depth; power of two, at least 2

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset
- OP_VALID  in  1  producer offers a pair
- OP_READY  out  1  injector accepts a pair
- OP_A  in  TDATAW  first operand
- OP_B  in  TDATAW  second operand
- OP_DEST  in  TDESTW  destination node of the adder
- AXIS_M_TVALID  out  1  beat valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  TDATAW  beat data
- AXIS_M_TLAST  out  1  high on beat B only
- AXIS_M_TID  out  TIDW  transaction ID
- AXIS_M_TDEST  out  TDESTW  destination
- FIFO_LEVEL  out  $clog2(DEPTH)+1  pairs currently queued
- PAIRS_SENT  out  16  count of completed pairs; saturates at 0xFFFF

Behaviour:
- Reset: RST_N is asynchronous and active-low; CLK is the clock.
  - All state registers, FIFO pointers, FIFO_LEVEL, TID counter and PAIRS_SENT clear to 0; the state machine returns to IDLE.
  - During reset: AXIS_M_TVALID=0, TDATA/TLAST/TID/TDEST=0, OP_READY=0.
- Input side:
  - OP_READY = !full, driven from registered level only; there is no same-cycle pass-through.
  - A push happens when OP_VALID && OP_READY; it stores {A, B, DEST} at the tail.
- FIFO:
  - Circular buffer; read and write pointers wrap at DEPTH.
  - Push and pop in the same cycle leave FIFO_LEVEL unchanged.
  - When full, a push is refused even if a pop occurs that cycle.
- State machine: IDLE, SEND_A, SEND_B; the state is registered.
  - IDLE: TVALID=0. If the FIFO is non-empty, next state is SEND_A.
  - SEND_A: TVALID=1, TDATA=head.A, TLAST=0, TDEST=head.DEST, TID=tid_cnt. On TREADY, next state is SEND_B.
  - SEND_B: TVALID=1, TDATA=head.B, TLAST=1, same TDEST and TID. On TREADY:
    - pop the head;
    - tid_cnt increments (wraps);
    - PAIRS_SENT increments (saturating);
    - next state is SEND_A if the FIFO holds another pair after this pop (level>1, or level==1 with a simultaneous push), else IDLE.
  - Otherwise, each state holds.
- AXIS rules:
  - Outputs are decoded from state and the FIFO head.
  - Once TVALID is asserted, it and TDATA/TLAST/TID/TDEST stay stable until TREADY.
  - TVALID never depends combinationally on TREADY.
- Latency: a pair pushed into an empty FIFO in cycle N shows beat A valid in cycle N+2 (level update, then IDLE→SEND_A).
- Throughput: back-to-back pairs stream with no idle cycle between B and the next A; peak rate is 1 beat/cycle.
- Data: operands pass unmodified at full width; no arithmetic is applied.
- Reset mid-operation:
  - Any in-flight pair and all queued pairs are discarded.
  - A beat already presented is dropped; TVALID goes low asynchronously.

Test Plan:
- Single pair: push A=5, B=7, DEST=0x1 with TREADY=1 → beat 5/TLAST=0 then beat 7/TLAST=1, both TID=0, TDEST=0x1; PAIRS_SENT=1; FIFO_LEVEL returns to 0.
- Backpressure: TREADY=0 for 3 cycles while in SEND_A with A=0x10 → TDATA held at 0x10, TVALID held at 1. Then TREADY=1 → beat B follows on the next cycle.
- Full FIFO: TREADY=0, push 5 pairs back-to-back → OP_READY drops after the 4th push; FIFO_LEVEL=4; the 5th pair is not accepted until the first pair's beat B handshakes.
- Streaming: TREADY=1, 5 pairs queued → 10 consecutive valid beats with no bubbles; TIDs 0,1,2,3,0; PAIRS_SENT=5.
- Reset mid-op: assert RST_N low after beat A handshakes, with 2 pairs queued → TVALID=0, FIFO_LEVEL=0, PAIRS_SENT=0. A new pair pushed afterwards starts with beat A at TID=0.
- Extremes: A=B=0xFFFFFFFF, DEST=0xF → beats carry 0xFFFFFFFF unaltered with TDEST=0xF.
